decode_stage: RTL and testbench

Instruction decode stage sitting directly downstream of the program-counter/instruction-ROM fetch block. Each cycle it captures the 32-bit instruction word from fetch, splits it into fields, reads two source operands from an internal 32×32 register file and presents a registered, decoded bundle to the execute stage. It also accepts register write-back from later stages, supports stall and flush, and has a sticky HALT state.

---
 rtl/cpu_pkg.sv | 87 ++++++++
 rtl/reg_file32.sv | 34 +++
 rtl/decode_stage.sv | 138 +++++++++++++
 tb/tb_decode_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the decode stage: opcodes, ALU codes, field positions, FSM states.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int XLEN = 32;

  // Opcode map
  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_ADD   = 6'h01;
  localparam logic [5:0] OP_SUB   = 6'h02;
  localparam logic [5:0] OP_AND   = 6'h03;
  localparam logic [5:0] OP_OR    = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LOAD  = 6'h10;
  localparam logic [5:0] OP_STORE = 6'h11;
  localparam logic [5:0] OP_JMP   = 6'h20;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  // ALU operation encodings
  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;

  // Instruction field bit positions
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 21;
  localparam int RS1_MSB = 20;
  localparam int RS1_LSB = 16;
  localparam int RS2_MSB = 15;
  localparam int RS2_LSB = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       use_imm;
    logic       reg_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    ctrl_t           ctrl;
  } bundle_t;

  // Control bits for one opcode; NOP and HALT decode to all-zero controls.
  function automatic ctrl_t decode_op(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_NOP, OP_HALT: ;
      OP_ADD:   begin c.reg_we = 1'b1; c.alu_op = ALU_ADD; end
      OP_SUB:   begin c.reg_we = 1'b1; c.alu_op = ALU_SUB; end
      OP_AND:   begin c.reg_we = 1'b1; c.alu_op = ALU_AND; end
      OP_OR:    begin c.reg_we = 1'b1; c.alu_op = ALU_OR;  end
      OP_ADDI:  begin c.use_imm = 1'b1; c.reg_we = 1'b1; c.alu_op = ALU_ADD; end
      OP_LOAD:  begin c.use_imm = 1'b1; c.reg_we = 1'b1; c.mem_rd = 1'b1; c.alu_op = ALU_ADD; end
      OP_STORE: begin c.use_imm = 1'b1; c.mem_wr = 1'b1; c.alu_op = ALU_ADD; end
      OP_JMP:   begin c.jump = 1'b1; c.use_imm = 1'b1; end
      default:  c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/reg_file32.sv
// 32x32 register file: two combinational read ports, one synchronous write port, r0 hard zero.
// Latency: reads 0 cycles (combinational), writes visible after the rising edge.
// Backpressure: none; a write is always accepted. RST clears every entry synchronously.
// Ports: i_clk, i_rst, i_raddr1/i_raddr2 -> o_rdata1/o_rdata2, i_we/i_waddr/i_wdata write port.
module reg_file32 #(
  parameter int NREG = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);

  logic [31:0] r_mem [NREG];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : r_mem[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : r_mem[i_raddr2];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode: field split, operand read with write-back bypass, registered decoded bundle.
// Latency: 1 cycle from INST capture to outputs; all outputs registered.
// Backpressure: stall holds every output; flush inserts a bubble and wins over stall; HALT is sticky until RST.
// Ports: CLK/RST; fetch side INST/in_valid; stall/flush; write-back wb_we/wb_addr/wb_data;
//        execute side out_valid, rd/rs1/rs2, op_a/op_b, alu_op, use_imm/reg_we/mem_rd/mem_wr/jump, illegal, halted.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] INST,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [3:0]  alu_op,
  output logic        use_imm,
  output logic        reg_we,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        jump,
  output logic        illegal,
  output logic        halted
);

  state_e  r_state;
  state_e  w_state_nxt;
  bundle_t r_bundle;
  bundle_t w_bundle_nxt;
  logic    r_halted;

  logic [5:0]  w_op;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [15:0] w_imm;
  logic [31:0] w_rf_a;
  logic [31:0] w_rf_b;
  logic [31:0] w_opa;
  logic [31:0] w_opb_reg;
  logic [31:0] w_opb;
  ctrl_t       w_ctrl;
  logic        w_capture;

  assign w_op  = INST[OP_MSB:OP_LSB];
  assign w_rd  = INST[RD_MSB:RD_LSB];
  assign w_rs1 = INST[RS1_MSB:RS1_LSB];
  assign w_rs2 = INST[RS2_MSB:RS2_LSB];
  assign w_imm = INST[IMM_MSB:IMM_LSB];

  reg_file32 #(.NREG(NREG)) u_rf (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rf_a),
    .o_rdata2 (w_rf_b),
    .i_we     (wb_we),
    .i_waddr  (wb_addr),
    .i_wdata  (wb_data)
  );

  // Bypass: a write landing on this edge must be seen by the instruction captured on it.
  assign w_opa     = (wb_we && (wb_addr == w_rs1) && (w_rs1 != 5'd0)) ? wb_data : w_rf_a;
  assign w_opb_reg = (wb_we && (wb_addr == w_rs2) && (w_rs2 != 5'd0)) ? wb_data : w_rf_b;

  assign w_ctrl = decode_op(w_op);
  assign w_opb  = w_ctrl.use_imm ? sext16(w_imm) : w_opb_reg;

  assign w_capture = (r_state == ST_RUN) && !flush && !stall;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_RUN;
      r_bundle <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bundle <= w_bundle_nxt;
      r_halted <= (w_state_nxt == ST_HALT);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_bundle_nxt = r_bundle;
    case (r_state)
      ST_RUN: begin
        if (flush) begin
          w_bundle_nxt.valid = 1'b0;
          w_bundle_nxt.ctrl  = '0;
        end else if (!stall) begin
          w_bundle_nxt.valid = in_valid;
          w_bundle_nxt.rd    = w_rd;
          w_bundle_nxt.rs1   = w_rs1;
          w_bundle_nxt.rs2   = w_rs2;
          w_bundle_nxt.op_a  = w_opa;
          w_bundle_nxt.op_b  = w_opb;
          w_bundle_nxt.ctrl  = in_valid ? w_ctrl : '0;
        end
        if (w_capture && in_valid && (w_op == OP_HALT)) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        w_bundle_nxt.valid = 1'b0;
        w_bundle_nxt.ctrl  = '0;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign out_valid = r_bundle.valid;
  assign rd        = r_bundle.rd;
  assign rs1       = r_bundle.rs1;
  assign rs2       = r_bundle.rs2;
  assign op_a      = r_bundle.op_a;
  assign op_b      = r_bundle.op_b;
  assign alu_op    = r_bundle.ctrl.alu_op;
  assign use_imm   = r_bundle.ctrl.use_imm;
  assign reg_we    = r_bundle.ctrl.reg_we;
  assign mem_rd    = r_bundle.ctrl.mem_rd;
  assign mem_wr    = r_bundle.ctrl.mem_wr;
  assign jump      = r_bundle.ctrl.jump;
  assign illegal   = r_bundle.ctrl.illegal;
  assign halted    = r_halted;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: reference model feeds a scoreboard queue, monitor compares each cycle.
module tb_decode_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] INST = '0;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] op_a, op_b;
  logic [3:0]  alu_op;
  logic        use_imm, reg_we, mem_rd, mem_wr, jump, illegal, halted;

  always #5 CLK = ~CLK;

  decode_stage #(.NREG(32)) dut (
    .CLK(CLK), .RST(RST), .INST(INST), .in_valid(in_valid), .stall(stall), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .rd(rd), .rs1(rs1), .rs2(rs2), .op_a(op_a), .op_b(op_b),
    .alu_op(alu_op), .use_imm(use_imm), .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .jump(jump), .illegal(illegal), .halted(halted)
  );

  typedef struct {
    bit        v;
    bit [4:0]  rd, rs1, rs2;
    bit [31:0] a, b;
    bit [3:0]  alu;
    bit        ui, we, mr, mw, j, ill, h;
  } exp_t;

  exp_t      sb_q[$];
  exp_t      cur;
  bit [31:0] regs [32];
  bit        m_halt;
  int        n_vec = 0;
  int        n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t no_ctrl(input exp_t e);
    exp_t r;
    r = e;
    r.alu = 0; r.ui = 0; r.we = 0; r.mr = 0; r.mw = 0; r.j = 0; r.ill = 0;
    return r;
  endfunction

  function automatic bit [31:0] read_reg(input bit [4:0] a, input bit we, input bit [4:0] wa,
                                         input bit [31:0] wd);
    if (a == 0) return 32'd0;
    if (we && wa == a) return wd;
    return regs[a];
  endfunction

  // Behavioural model of one clock edge given the inputs presented before it.
  task automatic model_step(input bit rst, input bit iv, input bit st, input bit fl,
                            input bit [31:0] inst, input bit we, input bit [4:0] wa,
                            input bit [31:0] wd);
    exp_t n;
    bit [5:0] op;
    n = cur;
    if (rst) begin
      n = '{default: 0};
      foreach (regs[i]) regs[i] = 0;
      m_halt = 0;
    end else begin
      if (m_halt || fl) begin
        n = no_ctrl(n);
        n.v = 0;
      end else if (!st) begin
        op = inst[31:26];
        n = no_ctrl(n);
        n.v = iv;
        n.rd = inst[25:21];
        n.rs1 = inst[20:16];
        n.rs2 = inst[15:11];
        n.a = read_reg(n.rs1, we, wa, wd);
        n.b = read_reg(n.rs2, we, wa, wd);
        if (iv) begin
          if (op >= 1 && op <= 4) begin n.we = 1; n.alu = op[3:0]; end
          else if (op == 6'h08) begin n.ui = 1; n.we = 1; n.alu = 1; end
          else if (op == 6'h10) begin n.ui = 1; n.we = 1; n.mr = 1; n.alu = 1; end
          else if (op == 6'h11) begin n.ui = 1; n.mw = 1; n.alu = 1; end
          else if (op == 6'h20) begin n.ui = 1; n.j = 1; end
          else if (op != 6'h00 && op != 6'h3F) n.ill = 1;
          if (n.ui) n.b = {{16{inst[15]}}, inst[15:0]};
          if (op == 6'h3F) m_halt = 1;
        end
      end
      if (we && wa != 0) regs[wa] = wd;
    end
    n.h = m_halt;
    cur = n;
    sb_q.push_back(n);
  endtask

  task automatic cyc(input bit rst, input bit iv, input bit st, input bit fl, input bit [31:0] inst,
                     input bit we, input bit [4:0] wa, input bit [31:0] wd);
    @(negedge CLK);
    RST = rst; in_valid = iv; stall = st; flush = fl; INST = inst;
    wb_we = we; wb_addr = wa; wb_data = wd;
    model_step(rst, iv, st, fl, inst, we, wa, wd);
  endtask

  task automatic after_edge();
    @(posedge CLK);
    #2;
  endtask

  // Monitor: one expected bundle per edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("out_valid", 32'(out_valid), 32'(e.v));
        chk("halted",    32'(halted),    32'(e.h));
        chk("alu_op",    32'(alu_op),    32'(e.alu));
        chk("ctrl",      {26'd0, use_imm, reg_we, mem_rd, mem_wr, jump, illegal},
                         {26'd0, e.ui, e.we, e.mr, e.mw, e.j, e.ill});
        if (e.v) begin
          chk("fields", {17'd0, rd, rs1, rs2}, {17'd0, e.rd, e.rs1, e.rs2});
          chk("op_a", op_a, e.a);
          chk("op_b", op_b, e.b);
        end
      end
    end
  end

  initial begin
    bit [5:0]  ops [10];
    bit [5:0]  op;
    bit [15:0] imm;
    bit        r;
    cur = '{default: 0};
    m_halt = 0;
    foreach (regs[i]) regs[i] = 0;
    ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h08, 6'h10, 6'h11, 6'h20, 6'h3F};

    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    after_edge();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_halted", 32'(halted), 0);

    // ADD r1, r2, r3 straight after reset
    cyc(0, 1, 0, 0, 32'h04221800, 0, 0, 0);
    after_edge();
    chk("add_valid", 32'(out_valid), 1);
    chk("add_reg_we", 32'(reg_we), 1);
    chk("add_alu", 32'(alu_op), 1);
    chk("add_op_a", op_a, 0);
    chk("add_op_b", op_b, 0);

    // ADDI r1, r5, -1 with write-back of r5 on the same edge
    cyc(0, 1, 0, 0, 32'h2025FFFF, 1, 5'd5, 32'hDEADBEEF);
    after_edge();
    chk("bypass_op_a", op_a, 32'hDEADBEEF);
    chk("bypass_op_b", op_b, 32'hFFFFFFFF);
    chk("bypass_use_imm", 32'(use_imm), 1);

    // Write to r0 is dropped; then read r0 and r5
    cyc(0, 0, 0, 0, 0, 1, 5'd0, 32'h12345678);
    cyc(0, 1, 0, 0, {6'h01, 5'd2, 5'd0, 5'd5, 11'd0}, 0, 0, 0);
    after_edge();
    chk("r0_op_a", op_a, 0);
    chk("r5_op_b", op_b, 32'hDEADBEEF);

    // Stall for three cycles with changing INST, then stall+flush
    cyc(0, 1, 0, 0, {6'h02, 5'd3, 5'd5, 5'd0, 11'd0}, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, $urandom, 1, 5'd5, $urandom);
    after_edge();
    chk("stall_op_a", op_a, 32'hDEADBEEF);
    chk("stall_alu", 32'(alu_op), 2);
    cyc(0, 1, 1, 1, 32'h04221800, 0, 0, 0);
    after_edge();
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_reg_we", 32'(reg_we), 0);

    // Illegal opcode, then in_valid low
    cyc(0, 1, 0, 0, {6'h15, 26'h2A5A5A5}, 0, 0, 0);
    after_edge();
    chk("ill_flag", 32'(illegal), 1);
    chk("ill_ctrl", {28'd0, reg_we, mem_rd, mem_wr, jump}, 0);
    cyc(0, 0, 0, 0, 32'h04221800, 0, 0, 0);
    after_edge();
    chk("inv_valid", 32'(out_valid), 0);
    chk("inv_ctrl", {25'd0, alu_op, reg_we, mem_rd, jump}, 0);

    // HALT is sticky until reset
    cyc(0, 1, 0, 0, 32'hFC000000, 0, 0, 0);
    after_edge();
    chk("halt_insn_valid", 32'(out_valid), 1);
    chk("halt_flag", 32'(halted), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, 32'h04221800, 1, 5'd7, 32'hCAFEF00D);
      after_edge();
      chk("halt_valid", 32'(out_valid), 0);
      chk("halt_sticky", 32'(halted), 1);
    end
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    after_edge();
    chk("rst_unhalt", 32'(halted), 0);
    cyc(0, 1, 0, 0, 32'h04221800, 0, 0, 0);
    after_edge();
    chk("post_halt_add", 32'(out_valid), 1);
    chk("post_halt_we", 32'(reg_we), 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      op = ($urandom_range(0, 10) == 10) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      imm = 16'($urandom);
      if ($urandom_range(0, 1) == 1) imm[15:11] = 5'($urandom_range(0, 7));
      r = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      cyc(r, $urandom_range(0, 4) != 0, $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
          {op, 5'($urandom), 5'($urandom_range(0, 7)), imm},
          $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
    end

    repeat (3) @(posedge CLK);
    #3;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected bundles left, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
